// File: rtl/joy_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : joy_serializer_if
//  Description : Host <-> device joystick serial link (JOY_CLK, JOY_LOAD,
//                JOY_DATA). The host side drives clock and load; the device
//                side returns serial data.
//  Revision    : 1.0 - initial release
// ============================================================================
interface joy_serializer_if;
  logic joy_clk_in;   // JOY_CLK from the host, asynchronous to clk
  logic joy_load_in;  // JOY_LOAD from the host, active-low parallel load
  logic joy_data;     // JOY_DATA back to the host

  modport master (output joy_clk_in, output joy_load_in, input joy_data);
  modport slave  (input joy_clk_in, input joy_load_in, output joy_data);
endinterface
`default_nettype wire

// File: rtl/joy_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : joy_serializer
//  Description : Device-side emulation of a two-player joystick PISO chain.
//                Snapshots both joystick words while JOY_LOAD is low, then
//                shifts one slot per synchronised JOY_CLK rising edge.
//                Slot 0 is driven first; slots 14.. are padding (1).
//  Options     : define JOYSER_WATCHDOG_EN to add a stall watchdog that forces
//                an idle (all-ones) line after WDOG_CYCLES quiet clk cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module joy_serializer #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  joy_serializer_if.slave       link,
  input  logic [7:0]            joystick1,
  input  logic [7:0]            joystick2,
  output logic                  frame_start,
  output logic [4:0]            bit_index
);

  // Reject parameter values the datapath cannot represent.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FRAME_BITS < 14 || FRAME_BITS > 32 ||
      WDOG_CYCLES < 1) begin : g_param_check
    $error("joy_serializer: illegal parameter combination");
  end

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [4:0] LAST_INDEX = 5'(FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  state_t                 state_q, state_d;
  logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
  logic [4:0]             bit_index_q, bit_index_d;
  logic                   frame_start_q, frame_start_d;

  logic                   clk_s;
  logic                   load_s;
  logic                   clk_rise;
  logic                   load_rise;
  logic                   wdog_hold;
  logic [FRAME_BITS-1:0]  frame_w;

  // Bits 6 and 7 of each joystick word are not part of the frame.
  logic unused_joy_bits;
  assign unused_joy_bits = ^{joystick1[7:6], joystick2[7:6]};

  assign clk_s     = clk_sync_q[SYNC_STAGES-1];
  assign load_s    = load_sync_q[SYNC_STAGES-1];
  assign clk_rise  = clk_s & ~clk_prev_q;
  assign load_rise = load_s & (state_q == ST_LOAD);

  // Parallel-load image: padding 1s everywhere except the twelve button slots.
  always_comb begin
    frame_w     = '1;
    frame_w[2]  = joystick1[5];
    frame_w[3]  = joystick1[4];
    frame_w[4]  = joystick1[0];
    frame_w[5]  = joystick1[1];
    frame_w[6]  = joystick1[2];
    frame_w[7]  = joystick1[3];
    frame_w[8]  = joystick2[5];
    frame_w[9]  = joystick2[4];
    frame_w[10] = joystick2[0];
    frame_w[11] = joystick2[1];
    frame_w[12] = joystick2[2];
    frame_w[13] = joystick2[3];
  end

`ifdef JOYSER_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_trip_q, wdog_trip_d;
  logic              link_activity;

  // Any synchronised transition of JOY_CLK or JOY_LOAD counts as host activity.
  assign link_activity = (clk_s != clk_prev_q) | (load_s != (state_q == ST_SHIFT));

  // Quiet-cycle counter saturates at the limit; the trip latches until load goes low.
  always_comb begin
    wdog_cnt_d  = wdog_cnt_q;
    if (link_activity) begin
      wdog_cnt_d = '0;
    end else if (wdog_cnt_q != WDOG_LIMIT) begin
      wdog_cnt_d = wdog_cnt_q + 1'b1;
    end
    wdog_trip_d = load_s & (wdog_trip_q | (~link_activity & (wdog_cnt_q == WDOG_LIMIT)));
  end

  // Watchdog state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_cnt_q  <= '0;
      wdog_trip_q <= 1'b0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_trip_q <= wdog_trip_d;
    end
  end

  assign wdog_hold = wdog_trip_q;
`else
  assign wdog_hold = 1'b0;
`endif

  // Next-state logic: load has priority, then watchdog, then a shift on a clk edge.
  always_comb begin
    clk_sync_d    = {clk_sync_q[SYNC_STAGES-2:0], link.joy_clk_in};
    load_sync_d   = {load_sync_q[SYNC_STAGES-2:0], link.joy_load_in};
    clk_prev_d    = clk_s;
    state_d       = load_s ? ST_SHIFT : ST_LOAD;
    frame_start_d = load_rise;
    shreg_d       = shreg_q;
    bit_index_d   = bit_index_q;

    if (!load_s) begin
      // Continuous reload: the last cycle before load rises holds the snapshot.
      shreg_d     = frame_w;
      bit_index_d = '0;
    end else if (wdog_hold) begin
      shreg_d     = '1;
      bit_index_d = '0;
    end else if (clk_rise && !load_rise) begin
      // A clk edge coinciding with the load release is dropped so slot 0 is not skipped.
      shreg_d = {1'b1, shreg_q[FRAME_BITS-1:1]};
      if (bit_index_q != LAST_INDEX) begin
        bit_index_d = bit_index_q + 5'd1;
      end
    end
  end

  // State registers; reset returns the line to idle-high in SHIFT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q    <= '1;
      load_sync_q   <= '1;
      clk_prev_q    <= 1'b1;
      state_q       <= ST_SHIFT;
      shreg_q       <= '1;
      bit_index_q   <= '0;
      frame_start_q <= 1'b0;
    end else begin
      clk_sync_q    <= clk_sync_d;
      load_sync_q   <= load_sync_d;
      clk_prev_q    <= clk_prev_d;
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_index_q   <= bit_index_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign link.joy_data = shreg_q[0];
  assign frame_start   = frame_start_q;
  assign bit_index     = bit_index_q;

endmodule
`default_nettype wire
